// File: rtl/mode_sequencer.sv
// Mode/pause controller for the four-mode LED display: divides clk into the
// processor step tick, gates it with pause, cycles modes and muxes the LEDs.
module mode_sequencer #(
    parameter int TICK_DIV = 25_000_000,
    parameter int CNT_W    = 25
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_pause,
    input  logic [7:0] leds_m0,
    input  logic [7:0] leds_m1,
    input  logic [7:0] leds_m2,
    input  logic [7:0] leds_m3,
    output logic [1:0] mode,
    output logic [3:0] mode_en,
    output logic       mode_rst,
    output logic       pause_out,
    output logic       tick_out,
    output logic [7:0] leds
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        PAUSED = 2'd1,
        SWITCH = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [1:0]       mode_nxt;
    logic             mode_rst_nxt;
    logic             pause_nxt;
    logic             tick_nxt;
    logic [7:0]       leds_nxt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // SWITCH lasts one cycle and ignores both buttons; btn_mode beats btn_pause.
    always_comb begin
        state_nxt = state;
        case (state)
            RUN: begin
                if (btn_mode) begin
                    state_nxt = SWITCH;
                end else if (btn_pause) begin
                    state_nxt = PAUSED;
                end
            end
            PAUSED: begin
                if (btn_mode) begin
                    state_nxt = SWITCH;
                end else if (btn_pause) begin
                    state_nxt = RUN;
                end
            end
            SWITCH:  state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    // The divider advances only on RUN->RUN and SWITCH->RUN edges; the resume
    // edge out of PAUSED still holds cnt, delaying the next tick by one cycle.
    always_comb begin
        mode_nxt     = mode;
        cnt_nxt      = cnt;
        mode_rst_nxt = 1'b0;
        pause_nxt    = 1'b0;
        tick_nxt     = 1'b0;
        case (state_nxt)
            SWITCH: begin
                mode_nxt     = mode + 2'd1;
                mode_rst_nxt = 1'b1;
                cnt_nxt      = '0;
            end
            PAUSED: begin
                pause_nxt = 1'b1;
            end
            default: begin
                if (state != PAUSED) begin
                    if (cnt == TICK_LAST) begin
                        cnt_nxt  = '0;
                        tick_nxt = 1'b1;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
            end
        endcase

        case (mode)
            2'd0:    leds_nxt = leds_m0;
            2'd1:    leds_nxt = leds_m1;
            2'd2:    leds_nxt = leds_m2;
            default: leds_nxt = leds_m3;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            mode      <= 2'd0;
            cnt       <= '0;
            mode_rst  <= 1'b0;
            pause_out <= 1'b0;
            tick_out  <= 1'b0;
            leds      <= 8'h00;
        end else begin
            mode      <= mode_nxt;
            cnt       <= cnt_nxt;
            mode_rst  <= mode_rst_nxt;
            pause_out <= pause_nxt;
            tick_out  <= tick_nxt;
            leds      <= leds_nxt;
        end
    end

    assign mode_en = 4'b0001 << mode;

endmodule

// File: tb/tb_mode_sequencer.sv
// Directed bench for mode_sequencer: one instance with TICK_DIV=4 and one
// with TICK_DIV=1 sharing clock and reset.
module tb_mode_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_mode, btn_pause, btn_mode_b, btn_pause_b;
    logic [7:0] m0, m1, m2, m3;

    logic [1:0] mode, mode_b;
    logic [3:0] mode_en, mode_en_b;
    logic       mode_rst, mode_rst_b, pause_out, pause_out_b, tick_out, tick_out_b;
    logic [7:0] leds, leds_b;

    logic [7:0] pat [4];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mode_sequencer #(.TICK_DIV(4), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .btn_mode(btn_mode), .btn_pause(btn_pause),
        .leds_m0(m0), .leds_m1(m1), .leds_m2(m2), .leds_m3(m3),
        .mode(mode), .mode_en(mode_en), .mode_rst(mode_rst),
        .pause_out(pause_out), .tick_out(tick_out), .leds(leds)
    );

    mode_sequencer #(.TICK_DIV(1), .CNT_W(1)) dut_b (
        .clk(clk), .reset(reset), .btn_mode(btn_mode_b), .btn_pause(btn_pause_b),
        .leds_m0(m0), .leds_m1(m1), .leds_m2(m2), .leds_m3(m3),
        .mode(mode_b), .mode_en(mode_en_b), .mode_rst(mode_rst_b),
        .pause_out(pause_out_b), .tick_out(tick_out_b), .leds(leds_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "bench did not finish");
    end

    initial begin
        int expm;
        int prevm;
        pat[0] = 8'h01; pat[1] = 8'h02; pat[2] = 8'h04; pat[3] = 8'h08;
        m0 = pat[0]; m1 = pat[1]; m2 = pat[2]; m3 = pat[3];
        reset = 1'b0;
        btn_mode = 1'b0; btn_pause = 1'b0; btn_mode_b = 1'b0; btn_pause_b = 1'b0;

        // Reset held for two edges
        step(); step();
        check("rst_mode", mode, 0);
        check("rst_mode_en", mode_en, 4'b0001);
        check("rst_mode_rst", mode_rst, 0);
        check("rst_pause", pause_out, 0);
        check("rst_tick", tick_out, 0);
        check("rst_leds", leds, 8'h00);
        check("rst_tick_b", tick_out_b, 0);

        reset = 1'b1;
        for (int j = 1; j <= 12; j++) begin
            step();
            check("rel_tick", tick_out, 32'((j % 4) == 0));
            check("rel_tick_b", tick_out_b, 1);
            if (j == 1) check("rel_leds", leds, 8'h01);
        end

        // Mode wrap, ten cycles per pulse; also covers LED mux and tick restart
        for (int p = 0; p < 4; p++) begin
            prevm = p;
            expm  = (p + 1) % 4;
            btn_mode = 1'b1; step(); btn_mode = 1'b0;
            check("wrap_mode", mode, expm);
            check("wrap_mode_en", mode_en, 32'(1 << expm));
            check("wrap_rst_hi", mode_rst, 1);
            check("wrap_tick_sw", tick_out, 0);
            check("wrap_leds_old", leds, pat[prevm]);
            for (int j = 1; j <= 9; j++) begin
                step();
                if (j == 1) begin
                    check("wrap_rst_lo", mode_rst, 0);
                    check("wrap_leds_new", leds, pat[expm]);
                end
                check("wrap_tick", tick_out, 32'((j % 4) == 0));
            end
        end

        // Pause when cnt==2 (cnt is 1 here, one more edge makes it 2)
        step();
        check("pre_pause_tick", tick_out, 0);
        btn_pause = 1'b1; step(); btn_pause = 1'b0;
        check("pause_hi", pause_out, 1);
        check("pause_tick", tick_out, 0);
        for (int j = 0; j < 10; j++) begin
            step();
            check("paused_hi", pause_out, 1);
            check("paused_tick", tick_out, 0);
        end
        btn_pause = 1'b1; step(); btn_pause = 1'b0;
        check("resume_pause", pause_out, 0);
        check("resume_tick0", tick_out, 0);
        step();
        check("resume_tick1", tick_out, 0);
        step();
        check("resume_tick2", tick_out, 1);

        // Simultaneous buttons with mode==1
        btn_mode = 1'b1; step(); btn_mode = 1'b0;
        check("to_mode1", mode, 1);
        step(); step();
        btn_mode = 1'b1; btn_pause = 1'b1; step(); btn_mode = 1'b0; btn_pause = 1'b0;
        check("simul_mode", mode, 2);
        check("simul_pause", pause_out, 0);
        check("simul_rst_hi", mode_rst, 1);
        step();
        check("simul_rst_lo", mode_rst, 0);
        check("simul_pause2", pause_out, 0);

        // Switch out of pause
        btn_pause = 1'b1; step(); btn_pause = 1'b0;
        check("sp_pause_hi", pause_out, 1);
        step(); step();
        btn_mode = 1'b1; step(); btn_mode = 1'b0;
        check("sp_mode", mode, 3);
        check("sp_pause_lo", pause_out, 0);
        check("sp_rst", mode_rst, 1);
        check("sp_tick_sw", tick_out, 0);
        for (int j = 1; j <= 4; j++) begin
            step();
            check("sp_tick", tick_out, 32'(j == 4));
        end

        // Buttons held into the SWITCH cycle are ignored
        btn_mode = 1'b1; step();
        check("ign_mode1", mode, 0);
        check("ign_rst_hi", mode_rst, 1);
        check("ign_leds_old", leds, 8'h08);
        btn_pause = 1'b1; step(); btn_mode = 1'b0; btn_pause = 1'b0;
        check("ign_mode2", mode, 0);
        check("ign_rst_lo", mode_rst, 0);
        check("ign_pause", pause_out, 0);
        check("ign_leds_new", leds, 8'h01);
        step();
        check("ign_mode3", mode, 0);

        // Pattern change on the active input shows one cycle later
        m0 = 8'hA5; step();
        check("led_follow", leds, 8'hA5);
        check("led_mode_en", mode_en, 4'b0001);

        // TICK_DIV==1 instance: switch, pause and resume
        btn_mode_b = 1'b1; step(); btn_mode_b = 1'b0;
        check("b_mode", mode_b, 1);
        check("b_rst", mode_rst_b, 1);
        check("b_tick_sw", tick_out_b, 0);
        step();
        check("b_tick_after_sw", tick_out_b, 1);
        check("b_rst_lo", mode_rst_b, 0);
        btn_pause_b = 1'b1; step(); btn_pause_b = 1'b0;
        check("b_pause_hi", pause_out_b, 1);
        check("b_pause_tick", tick_out_b, 0);
        step();
        check("b_paused_tick", tick_out_b, 0);
        btn_pause_b = 1'b1; step(); btn_pause_b = 1'b0;
        check("b_resume_pause", pause_out_b, 0);
        check("b_resume_tick0", tick_out_b, 0);
        step();
        check("b_resume_tick1", tick_out_b, 1);

        // Reset overrides a pending button while paused
        btn_pause = 1'b1; step(); btn_pause = 1'b0;
        check("mid_pause_hi", pause_out, 1);
        reset = 1'b0; btn_mode = 1'b1; step(); reset = 1'b1; btn_mode = 1'b0;
        check("mid_mode", mode, 0);
        check("mid_pause", pause_out, 0);
        check("mid_rst", mode_rst, 0);
        check("mid_tick", tick_out, 0);
        check("mid_leds", leds, 8'h00);
        check("mid_mode_b", mode_b, 0);
        check("mid_tick_b", tick_out_b, 0);
        step();
        check("post_tick_b", tick_out_b, 1);
        check("post_tick", tick_out, 0);
        check("post_leds", leds, 8'hA5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
